// File: rtl/mux4x1_trio_checker.sv
// Registered 4:1 mux built three independent ways (dataflow, gate-level, 2:1 tree),
// with a self-check stage that counts agreeing results over a fixed sample window.
module mux4x1_trio_checker #(
  parameter int unsigned CHECK_LEN = 64,
  parameter int unsigned CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       a,
  input  logic             s0,
  input  logic             s1,
  output logic             y,
  output logic             y_cond,
  output logic             y_str,
  output logic             y_tree,
  output logic             out_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] match_count,
  output logic             done,
  output logic             pass
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(CHECK_LEN - 1);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(CHECK_LEN);

  // Conditional dataflow path
  logic cond_out;
  assign cond_out = s1 ? (s0 ? a[3] : a[2]) : (s0 ? a[1] : a[0]);

  // Gate-level sum of products; keeps its own inverted selects
  logic str_s0_n, str_s1_n, str_out;
  assign str_s0_n = ~s0;
  assign str_s1_n = ~s1;
  assign str_out  = (a[0] & str_s1_n & str_s0_n) | (a[1] & str_s1_n & s0) |
                    (a[2] & s1 & str_s0_n)       | (a[3] & s1 & s0);

  // Tree of three 2:1 muxes
  logic tree_lo, tree_hi, tree_out;
  assign tree_lo  = s0 ? a[1] : a[0];
  assign tree_hi  = s0 ? a[3] : a[2];
  assign tree_out = s1 ? tree_hi : tree_lo;

  logic             y_cond_q, y_str_q, y_tree_q, out_valid_q, done_q, pass_q;
  logic [CNT_W-1:0] sample_cnt_q, match_cnt_q;
  logic             accept, all_eq;
  logic [CNT_W-1:0] match_cnt_d;

  assign accept      = in_valid & ~done_q;
  assign all_eq      = (cond_out == str_out) & (cond_out == tree_out);
  assign match_cnt_d = match_cnt_q + {{(CNT_W-1){1'b0}}, all_eq};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_cond_q     <= 1'b0;
      y_str_q      <= 1'b0;
      y_tree_q     <= 1'b0;
      out_valid_q  <= 1'b0;
      sample_cnt_q <= '0;
      match_cnt_q  <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      out_valid_q <= accept;
      if (accept) begin
        y_cond_q     <= cond_out;
        y_str_q      <= str_out;
        y_tree_q     <= tree_out;
        sample_cnt_q <= sample_cnt_q + 1'b1;
        match_cnt_q  <= match_cnt_d;
        // Final sample: done/pass land in the same cycle as its result
        if (sample_cnt_q == LastIdx) begin
          done_q <= 1'b1;
          pass_q <= (match_cnt_d == FullCnt);
        end
      end
    end
  end

  assign y           = y_cond_q;
  assign y_cond      = y_cond_q;
  assign y_str       = y_str_q;
  assign y_tree      = y_tree_q;
  assign out_valid   = out_valid_q;
  assign mismatch    = out_valid_q & ((y_cond_q != y_str_q) | (y_cond_q != y_tree_q));
  assign match_count = match_cnt_q;
  assign done        = done_q;
  assign pass        = pass_q;

endmodule

// File: tb/tb_mux4x1_trio_checker.sv
// Directed bench for mux4x1_trio_checker: sweep, spot values, gaps, resets, post-done
// behaviour and an injected fault on the tree path.
module tb_mux4x1_trio_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic       s0, s1;
  logic       y, y_cond, y_str, y_tree, out_valid, mismatch, done, pass;
  logic [6:0] match_count;

  int checks = 0;
  int errors = 0;

  mux4x1_trio_checker #(.CHECK_LEN(64), .CNT_W(7)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .a           (a),
    .s0          (s0),
    .s1          (s1),
    .y           (y),
    .y_cond      (y_cond),
    .y_str       (y_str),
    .y_tree      (y_tree),
    .out_valid   (out_valid),
    .mismatch    (mismatch),
    .match_count (match_count),
    .done        (done),
    .pass        (pass)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, then advance one edge and settle 1 time unit past it
  task automatic step(input logic v, input logic [3:0] av, input logic s0v, input logic s1v);
    in_valid = v;
    a        = av;
    s0       = s0v;
    s1       = s1v;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " y"}, {31'd0, y}, 32'd0);
    check({tag, " y_cond"}, {31'd0, y_cond}, 32'd0);
    check({tag, " y_str"}, {31'd0, y_str}, 32'd0);
    check({tag, " y_tree"}, {31'd0, y_tree}, 32'd0);
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, " mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, " match_count"}, {25'd0, match_count}, 32'd0);
    check({tag, " done"}, {31'd0, done}, 32'd0);
    check({tag, " pass"}, {31'd0, pass}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic exp_y, input int exp_cnt,
                              input logic exp_done);
    check({tag, " y"}, {31'd0, y}, {31'd0, exp_y});
    check({tag, " y_str"}, {31'd0, y_str}, {31'd0, exp_y});
    check({tag, " y_tree"}, {31'd0, y_tree}, {31'd0, exp_y});
    check({tag, " out_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, " mismatch"}, {31'd0, mismatch}, 32'd0);
    check({tag, " match_count"}, {25'd0, match_count}, exp_cnt);
    check({tag, " done"}, {31'd0, done}, {31'd0, exp_done});
  endtask

  initial begin
    logic [5:0] vec;
    logic [3:0] av;
    logic [1:0] sel;
    logic       ey;

    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    step(1'b1, 4'hF, 1'b1, 1'b1);
    check_zero("reset");
    rst_n = 1'b1;

    // Exhaustive sweep: {a3,a2,a1,a0,s0,s1} = i
    for (int i = 0; i < 64; i++) begin
      vec = 6'(i);
      av  = vec[5:2];
      sel = {vec[0], vec[1]};
      ey  = av[sel];
      step(1'b1, av, vec[1], vec[0]);
      check_result("sweep", ey, i + 1, i == 63);
    end
    check("sweep pass", {31'd0, pass}, 32'd1);

    // Post-done: further valid samples are ignored
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'h0, 1'b0, 1'b0);
      check("postdone out_valid", {31'd0, out_valid}, 32'd0);
      check("postdone match_count", {25'd0, match_count}, 32'd64);
      check("postdone done", {31'd0, done}, 32'd1);
      check("postdone pass", {31'd0, pass}, 32'd1);
      check("postdone y hold", {31'd0, y}, 32'd1);
    end

    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check_zero("reset2");
    rst_n = 1'b1;

    // Spot values
    step(1'b1, 4'b1010, 1'b1, 1'b0);
    check_result("spot 1010/01", 1'b1, 1, 1'b0);
    step(1'b1, 4'b1010, 1'b0, 1'b1);
    check_result("spot 1010/10", 1'b0, 2, 1'b0);
    step(1'b1, 4'b0001, 1'b0, 1'b0);
    check_result("spot 0001/00", 1'b1, 3, 1'b0);
    step(1'b1, 4'b1000, 1'b1, 1'b1);
    check_result("spot 1000/11", 1'b1, 4, 1'b0);

    // Gaps: each of the remaining 60 samples followed by an idle cycle
    for (int k = 0; k < 60; k++) begin
      av  = 4'(k) ^ 4'h5;
      sel = 2'(k);
      ey  = av[sel];
      step(1'b1, av, sel[0], sel[1]);
      check_result("gap sample", ey, 5 + k, k == 59);
      step(1'b0, ~av, ~sel[0], ~sel[1]);
      check("gap out_valid", {31'd0, out_valid}, 32'd0);
      check("gap y hold", {31'd0, y}, {31'd0, ey});
      check("gap y_tree hold", {31'd0, y_tree}, {31'd0, ey});
      check("gap match_count", {25'd0, match_count}, 5 + k);
      check("gap done", {31'd0, done}, {31'd0, k == 59});
    end
    check("gap pass", {31'd0, pass}, 32'd1);

    // Reset mid-window after 30 samples
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) step(1'b1, 4'hF, 1'b0, 1'b0);
    check("mid pre-reset count", {25'd0, match_count}, 32'd30);
    rst_n = 1'b0;
    step(1'b1, 4'hF, 1'b1, 1'b0);
    check_zero("mid reset");
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      av  = 4'(i * 3);
      sel = 2'(i >> 2);
      ey  = av[sel];
      step(1'b1, av, sel[0], sel[1]);
      check_result("mid window", ey, i + 1, i == 63);
    end
    check("mid pass", {31'd0, pass}, 32'd1);

    // Fault: tree path inverted for a whole window
    rst_n = 1'b0;
    step(1'b0, 4'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      av  = 4'(i * 7 + 1);
      sel = 2'(i);
      ey  = av[sel];
      force dut.tree_out = ~ey;
      step(1'b1, av, sel[0], sel[1]);
      check("fault y", {31'd0, y}, {31'd0, ey});
      check("fault y_tree", {31'd0, y_tree}, {31'd0, ~ey});
      check("fault mismatch", {31'd0, mismatch}, 32'd1);
      check("fault match_count", {25'd0, match_count}, 32'd0);
      check("fault done", {31'd0, done}, {31'd0, i == 63});
    end
    release dut.tree_out;
    check("fault pass", {31'd0, pass}, 32'd0);
    step(1'b0, 4'h0, 1'b0, 1'b0);
    check("fault mismatch gated", {31'd0, mismatch}, 32'd0);
    check("fault done sticky", {31'd0, done}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
